// File: rtl/axis_gen_sched_pkg.sv
// Shared types and helpers for the AXIS payload-generator run scheduler.
package axis_gen_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    GAP,
    ABORT,
    DONE
  } sched_state_e;

  localparam int unsigned MIN_GAP    = 2;
  localparam int unsigned LEN_WIDTH  = 32;
  localparam int unsigned STAT_WIDTH = 64;

  function automatic logic axis_beat(input logic tvalid, input logic tready);
    return tvalid & tready;
  endfunction

  function automatic logic axis_completion(input logic tvalid, input logic tready,
                                           input logic tlast);
    return tvalid & tready & tlast;
  endfunction

  function automatic logic is_active_state(input sched_state_e s);
    return (s == LAUNCH) || (s == RUN) || (s == GAP);
  endfunction

endpackage

// File: rtl/axis_gen_stats.sv
// Run statistics: completed frames, bytes and active cycles, cleared at run start.
module axis_gen_stats
  import axis_gen_sched_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   frame_inc,
  input  logic                   active_inc,
  input  logic [LEN_WIDTH-1:0]   frame_len,
  output logic [COUNT_WIDTH-1:0] frames_sent,
  output logic [STAT_WIDTH-1:0]  bytes_sent,
  output logic [STAT_WIDTH-1:0]  active_cycles
);

  logic [COUNT_WIDTH-1:0] frames_q, frames_d;
  logic [STAT_WIDTH-1:0]  bytes_q, bytes_d;
  logic [STAT_WIDTH-1:0]  active_q, active_d;

  // All counters wrap naturally; clear wins over any same-cycle increment.
  always_comb begin
    frames_d = frames_q;
    bytes_d  = bytes_q;
    active_d = active_q;
    if (clr) begin
      frames_d = '0;
      bytes_d  = '0;
      active_d = '0;
    end else begin
      if (frame_inc) begin
        frames_d = frames_q + COUNT_WIDTH'(1);
        bytes_d  = bytes_q + STAT_WIDTH'(frame_len);
      end
      if (active_inc) active_d = active_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      bytes_q  <= '0;
      active_q <= '0;
    end else begin
      frames_q <= frames_d;
      bytes_q  <= bytes_d;
      active_q <= active_d;
    end
  end

  assign frames_sent   = frames_q;
  assign bytes_sent    = bytes_q;
  assign active_cycles = active_q;

endmodule

// File: rtl/axis_data_gen_scheduler.sv
// Sequences bursts of N generator frames with a programmable idle gap, tracks
// completion on the tapped output handshake and reports run status/statistics.
module axis_data_gen_scheduler
  import axis_gen_sched_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned GAP_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_abort,
  input  logic [LEN_WIDTH-1:0]   cfg_length,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  output logic                   gen_start,
  output logic                   gen_stop,
  output logic [LEN_WIDTH-1:0]   gen_length,
  input  logic                   mon_tvalid,
  input  logic                   mon_tready,
  input  logic                   mon_tlast,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] frames_sent,
  output logic [STAT_WIDTH-1:0]  bytes_sent,
  output logic [STAT_WIDTH-1:0]  active_cycles
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]      TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_WIDTH-1:0] MIN_GAP_W = GAP_WIDTH'(MIN_GAP);

  sched_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   error_q, error_d;
  logic                   zl_done_q, zl_done_d;
  logic                   stop_q, stop_d;

  logic                   beat, complete, last_frame, stats_clr;
  logic [TO_W-1:0]        to_cnt_inc;
  logic [GAP_WIDTH-1:0]   gap_cnt_inc;

  assign beat        = axis_beat(mon_tvalid, mon_tready);
  assign complete    = axis_completion(mon_tvalid, mon_tready, mon_tlast);
  assign to_cnt_inc  = to_cnt_q + TO_W'(1);
  assign gap_cnt_inc = gap_cnt_q + GAP_WIDTH'(1);
  assign last_frame  = (count_q != '0) && ((frames_sent + COUNT_WIDTH'(1)) == count_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    error_d   = error_q;
    zl_done_d = 1'b0;
    stats_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_length != '0) begin
            len_d     = cfg_length;
            count_d   = cfg_count;
            gap_d     = (cfg_gap < MIN_GAP_W) ? MIN_GAP_W : cfg_gap;
            error_d   = 1'b0;
            stats_clr = 1'b1;
            state_d   = LAUNCH;
          end else begin
            error_d   = 1'b1;
            zl_done_d = 1'b1;
          end
        end
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = cfg_abort ? ABORT : RUN;
      end
      RUN: begin
        to_cnt_d = beat ? '0 : to_cnt_inc;
        if (cfg_abort) begin
          state_d = ABORT;
        end else if (complete) begin
          gap_cnt_d = '0;
          state_d   = last_frame ? DONE : GAP;
        end else if (!beat && (to_cnt_inc == TO_LIMIT)) begin
          error_d = 1'b1;
          state_d = ABORT;
        end
      end
      GAP: begin
        // The minimum gap of two cycles lets the generator's start edge detector re-arm.
        gap_cnt_d = gap_cnt_inc;
        if (cfg_abort)                 state_d = ABORT;
        else if (gap_cnt_inc == gap_q) state_d = LAUNCH;
      end
      ABORT: begin
        if (complete || !mon_tvalid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stop_d = (state_d == ABORT) && (state_q != ABORT);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      error_q   <= 1'b0;
      zl_done_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      error_q   <= error_d;
      zl_done_q <= zl_done_d;
      stop_q    <= stop_d;
    end
  end

  axis_gen_stats #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .clr          (stats_clr),
    .frame_inc    (complete && (state_q != IDLE) && (state_q != DONE)),
    .active_inc   (is_active_state(state_q)),
    .frame_len    (len_q),
    .frames_sent  (frames_sent),
    .bytes_sent   (bytes_sent),
    .active_cycles(active_cycles)
  );

  assign gen_start  = (state_q == LAUNCH);
  assign gen_stop   = stop_q;
  assign gen_length = len_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) || zl_done_q;
  assign error      = error_q;

endmodule
